ascii2dec_tx: RTL and testbench
===============================

ASCII2DEC_TX -- requirements
Module: ascii2dec_tx

Interface
REQ-001 SHALL provide parameter GAP_CYC, default 2, number of idle cycles forced after every burst (range 1..7).
REQ-002 SHALL provide parameter BLANK, default 4'hF, digit code meaning "segment off".
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_valid  input  1  upstream character valid.
REQ-006 SHALL have port i_ascii  input  8  upstream ASCII character.
REQ-007 SHALL have port o_ready  output  1  character accepted this cycle when i_valid && o_ready.
REQ-008 SHALL have port o_rd  output  1  burst strobe toward the 3-digit display consumer.
REQ-009 SHALL have port o_dec  output  4  digit code toward the display consumer.
REQ-010 SHALL have port o_err  output  1  one-cycle pulse flagging an illegal character.
REQ-011 SHALL have port o_busy  output  1  high whenever the state is not COLLECT.

Function
REQ-012 SHALL implement states COLLECT, BURST, GAP; all outputs are registered.
REQ-013 SHALL assert o_ready only in COLLECT.
REQ-014 SHALL, on accept, map '0'..'9' (8'h30..8'h39) to 4'd0..4'd9 and store the result at frame index idx (0..2), then increment idx.
REQ-015 SHALL map space (8'h20) to BLANK with no error.
REQ-016 SHALL map any other character except CR (8'h0D) to BLANK, store it, and pulse o_err on the cycle after the accept.
REQ-017 SHALL, on accepting CR with idx 1 or 2, fill the remaining indices with BLANK and end the frame; CR stores nothing itself.
REQ-018 SHALL silently discard CR accepted with idx 0: no burst, no error, stays in COLLECT.
REQ-019 SHALL move COLLECT->BURST on the edge that accepts the 3rd character or a frame-ending CR, and reset idx to 0.
REQ-020 SHALL, with BURST cycles numbered b0..b3, drive o_rd=1 in b0, b1, b2 and o_rd=0 in b3.
REQ-021 SHALL drive o_dec=d0 in b1, d1 in b2, d2 in b3, and BLANK in every other cycle. This one-cycle data lag matches the consumer's registered strobe.
REQ-022 SHALL move BURST->GAP after b3, hold o_rd=0 and o_ready=0 for exactly GAP_CYC cycles, then move GAP->COLLECT.
REQ-023 SHALL ignore i_valid and i_ascii outside COLLECT; a held i_valid is accepted on the first COLLECT cycle.
REQ-024 SHALL guarantee at least GAP_CYC+1 consecutive o_rd=0 cycles between bursts, so the consumer's capture counter re-zeroes.
REQ-025 SHALL never assert o_rd for more or fewer than 3 consecutive cycles.

Reset
REQ-026 SHALL, while rst=0, force state=COLLECT, idx=0, burst/gap counters=0, o_rd=0, o_dec=BLANK, o_err=0, o_busy=0, stored digits=BLANK.
REQ-027 SHALL keep o_ready=0 during reset and drive o_ready=1 from the first clock edge after rst deasserts.
REQ-028 SHALL abandon any partial frame or burst on reset mid-operation, with no residual o_rd cycles after release.

Verification
REQ-029 SHALL cover: send "1","2","3" -> o_rd high 3 cycles; o_dec = 1,2,3 on the 3 cycles after o_rd rises; then BLANK; o_ready returns 1 after GAP_CYC idle cycles.
REQ-030 SHALL cover: send "7",CR -> burst with o_dec = 7,F,F; no o_err.
REQ-031 SHALL cover: send "A","4","5" -> o_err pulses once after "A" is accepted; burst o_dec = F,4,5.
REQ-032 SHALL cover: CR alone, then "9","8","0" -> no burst for the CR; single burst 9,8,0.
REQ-033 SHALL cover: i_valid held high continuously with 6 digits -> two bursts separated by >= GAP_CYC+1 o_rd=0 cycles; no character lost or duplicated.
REQ-034 SHALL cover: rst pulled low during b1 of a burst -> o_rd=0 and o_dec=F immediately; after release a new 3-character frame bursts correctly.

Source files
------------

// File: rtl/ascii2dec_tx.sv
// ASCII-to-digit framer: collects three characters (or fewer ended by CR) and
// replays them to a 3-digit display consumer as a fixed strobe burst plus idle gap.
module ascii2dec_tx #(
   parameter int         GAP_CYC = 2,
   parameter logic [3:0] BLANK   = 4'hF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_valid,
   input  logic [7:0] i_ascii,
   output logic       o_ready,
   output logic       o_rd,
   output logic [3:0] o_dec,
   output logic       o_err,
   output logic       o_busy
);

   // Handshake: a character transfers on a rising edge where i_valid && o_ready.
   typedef enum logic [1:0] {COLLECT, BURST, GAP} state_t;

   state_t     r_state;
   logic [1:0] r_idx;
   logic [1:0] r_bcnt;
   logic [2:0] r_gcnt;
   logic [3:0] r_dig [3];
   logic       r_ready;
   logic       r_rd;
   logic [3:0] r_dec;
   logic       r_err;
   logic       r_busy;

   logic       w_accept;
   logic       w_is_cr;
   logic       w_is_digit;
   logic       w_illegal;
   logic [3:0] w_code;
   logic       w_start;

   always_comb begin
      w_accept   = i_valid && r_ready;
      w_is_cr    = (i_ascii == 8'h0D);
      w_is_digit = (i_ascii >= 8'h30) && (i_ascii <= 8'h39);
      w_illegal  = !w_is_digit && (i_ascii != 8'h20);
      w_code     = w_is_digit ? i_ascii[3:0] : BLANK;
      // A frame ends on the 3rd stored character or on a CR after at least one.
      w_start    = w_accept && (w_is_cr ? (r_idx != 2'd0) : (r_idx == 2'd2));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= COLLECT;
         r_idx   <= 2'd0;
         r_bcnt  <= 2'd0;
         r_gcnt  <= 3'd0;
         for (int i = 0; i < 3; i++) r_dig[i] <= BLANK;
         r_ready <= 1'b0;
         r_rd    <= 1'b0;
         r_dec   <= BLANK;
         r_err   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            COLLECT: begin
               r_ready <= !w_start;
               r_busy  <= w_start;
               r_rd    <= w_start;
               r_dec   <= BLANK;
               if (w_accept && !w_is_cr) begin
                  r_dig[r_idx] <= w_code;
                  r_err        <= w_illegal;
                  r_idx        <= r_idx + 2'd1;
               end
               if (w_accept && w_is_cr && (r_idx != 2'd0)) begin
                  for (int i = 1; i < 3; i++)
                     if (2'(i) >= r_idx) r_dig[i] <= BLANK;
               end
               if (w_start) begin
                  r_state <= BURST;
                  r_idx   <= 2'd0;
                  r_bcnt  <= 2'd0;
               end
            end
            BURST: begin
               // Data trails the strobe by one cycle to suit the consumer's registered capture.
               r_bcnt <= r_bcnt + 2'd1;
               case (r_bcnt)
                  2'd0: begin r_rd <= 1'b1; r_dec <= r_dig[0]; end
                  2'd1: begin r_rd <= 1'b1; r_dec <= r_dig[1]; end
                  2'd2: begin r_rd <= 1'b0; r_dec <= r_dig[2]; end
                  default: begin
                     r_rd    <= 1'b0;
                     r_dec   <= BLANK;
                     r_state <= GAP;
                     r_gcnt  <= 3'd0;
                  end
               endcase
            end
            GAP: begin
               r_rd  <= 1'b0;
               r_dec <= BLANK;
               if (r_gcnt == 3'(GAP_CYC - 1)) begin
                  r_state <= COLLECT;
                  r_gcnt  <= 3'd0;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_gcnt <= r_gcnt + 3'd1;
               end
            end
            default: begin
               r_state <= COLLECT;
               r_ready <= 1'b0;
               r_busy  <= 1'b0;
               r_rd    <= 1'b0;
               r_dec   <= BLANK;
            end
         endcase
      end
   end

   assign o_ready = r_ready;
   assign o_rd    = r_rd;
   assign o_dec   = r_dec;
   assign o_err   = r_err;
   assign o_busy  = r_busy;

endmodule

// File: tb/tb_ascii2dec_tx.sv
// Directed scoreboard bench for ascii2dec_tx: frames are queued as expected digits,
// a negedge monitor pops and compares them against each observed burst.
module tb_ascii2dec_tx;

   localparam int         GAP = 2;
   localparam logic [3:0] BL  = 4'hF;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       i_valid = 1'b0;
   logic [7:0] i_ascii = 8'h00;
   logic       o_ready, o_rd, o_err, o_busy;
   logic [3:0] o_dec;

   ascii2dec_tx #(.GAP_CYC(GAP), .BLANK(BL)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_ascii(i_ascii),
      .o_ready(o_ready), .o_rd(o_rd), .o_dec(o_dec), .o_err(o_err), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [3:0] exp_q[$];
   int         err_exp = 0;
   int         err_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: burst data, strobe width, gap length, ready return, error pulses.
   logic prev_rd = 0, prev_err = 0, have_prev = 0, wait_ready = 0;
   int   phase = 0, rd_run = 0, low_run = 0, ready_wait = 0;

   always @(negedge clk) begin
      if (!rst) begin
         prev_rd = 0; prev_err = 0; have_prev = 0; wait_ready = 0;
         phase = 0; rd_run = 0; low_run = 0; ready_wait = 0;
      end else begin
         if (phase > 0) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL burst_dec: actual %0h with no expected digit queued", o_dec);
            end else begin
               check("burst_dec", o_dec, exp_q.pop_front());
            end
            phase = (phase == 3) ? 0 : phase + 1;
         end
         if (o_rd) begin
            if (!prev_rd) begin
               if (have_prev) check("gap_len_ok", low_run >= GAP + 1, 1);
               check("dec_blank_b0", o_dec, BL);
               phase = 1; rd_run = 0; have_prev = 1;
            end
            rd_run++;
         end else begin
            if (prev_rd) begin
               check("rd_width", rd_run, 3);
               low_run = 0; wait_ready = 1; ready_wait = 0;
            end
            low_run++;
         end
         if (wait_ready) begin
            if (o_ready) begin
               check("ready_after_gap", ready_wait, GAP + 1);
               wait_ready = 0;
            end else begin
               ready_wait++;
            end
         end
         if (o_err) begin
            err_seen++;
            check("err_single_cycle", prev_err, 0);
         end
         prev_err = o_err;
         prev_rd  = o_rd;
      end
   end

   task automatic send(input logic [7:0] c);
      int n = 0;
      @(negedge clk);
      i_valid = 1'b1;
      i_ascii = c;
      if (!((c >= 8'h30 && c <= 8'h39) || c == 8'h20 || c == 8'h0D)) err_exp++;
      while (!o_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!o_ready) begin
         checks++; errors++;
         $display("FAIL send_timeout: o_ready %0b expected 1", o_ready);
      end
      @(posedge clk);
   endtask

   task automatic push3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
      exp_q.push_back(a);
      exp_q.push_back(b);
      exp_q.push_back(c);
   endtask

   task automatic finish_frame(input string name);
      int n = 0;
      @(negedge clk);
      i_valid = 1'b0;
      while ((exp_q.size() != 0 || !o_ready) && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      check({name, "_queue_empty"}, exp_q.size(), 0);
      check({name, "_err_count"}, err_seen, err_exp);
   endtask

   initial begin
      #12;
      check("rst_ready", o_ready, 0);
      check("rst_rd", o_rd, 0);
      check("rst_dec", o_dec, BL);
      check("rst_err", o_err, 0);
      check("rst_busy", o_busy, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("ready_after_release", o_ready, 1);
      check("busy_after_release", o_busy, 0);

      push3(4'd1, 4'd2, 4'd3);
      send("1"); send("2"); send("3");
      finish_frame("t_123");

      push3(4'd7, BL, BL);
      send("7"); send(8'h0D);
      finish_frame("t_7cr");

      push3(BL, 4'd4, 4'd5);
      send("A"); send("4"); send("5");
      finish_frame("t_A45");

      send(8'h0D);
      @(negedge clk);
      i_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("cr_alone_busy", o_busy, 0);
      check("cr_alone_rd", o_rd, 0);
      push3(4'd9, 4'd8, 4'd0);
      send("9"); send("8"); send("0");
      finish_frame("t_cr_980");

      push3(BL, 4'd5, BL);
      send(" "); send("5"); send(8'h0D);
      finish_frame("t_sp5cr");

      push3(4'd1, 4'd2, 4'd3);
      push3(4'd4, 4'd5, 4'd6);
      send("1"); send("2"); send("3"); send("4"); send("5"); send("6");
      finish_frame("t_held6");

      push3(4'd1, 4'd2, 4'd3);
      send("1"); send("2"); send("3");
      @(negedge clk);
      i_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("midburst_rst_rd", o_rd, 0);
      check("midburst_rst_dec", o_dec, BL);
      check("midburst_rst_busy", o_busy, 0);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      push3(4'd4, 4'd5, 4'd6);
      send("4"); send("5"); send("6");
      finish_frame("t_after_rst");

      check("total_err_pulses", err_seen, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
